// File: rtl/arb_pkg.sv
// Shared state encoding, mux selects and counter helpers for the CPU/DMA memory bus arbiter.
package arb_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    CPU_OWN   = 2'b00,
    HALT_WAIT = 2'b01,
    DMA_OWN   = 2'b10,
    HANDBACK  = 2'b11
  } arb_state_e;

  localparam logic MUX_CPU = 1'b0;
  localparam logic MUX_DMA = 1'b1;

  // Parameters arrive as int; counters are CNT_W bits wide.
  function automatic logic [CNT_W-1:0] to_cnt(input int unsigned v);
    return v[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/arb_cycle_counter.sv
// Saturating cycle counter with load, increment and decrement; used for burst length and CPU gap.
module arb_cycle_counter
  import arb_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (inc && !dec) begin
      if (count_q != '1) count_d = count_q + CNT_W'(1);
    end else if (dec && !inc) begin
      if (count_q != '0) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one synchronous memory port between the 6502 (stalled via RDY) and a DMA master.
// Build option: define ARB_WP_EN to suppress DMA writes at or above WP_BASE and flag them.
//
// state     | meaning
// CPU_OWN   | CPU drives the memory port, RDY high
// HALT_WAIT | RDY low; CPU write cycles still pass through until the CPU reaches a read
// DMA_OWN   | DMA master owns the port, one transfer per acked cycle
// HANDBACK  | stalled CPU read replayed at cpu_addr; RDY returns next cycle
module mem_bus_arbiter
  import arb_pkg::*;
#(
  parameter int                MAX_BURST = 16,
  parameter int                CPU_GAP   = 4,
  parameter int                ADDR_W    = 16,
  parameter int                DATA_W    = 8,
  parameter logic [ADDR_W-1:0] WP_BASE   = ADDR_W'(16'hFF00)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rdy,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic              dma_we,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_rvalid,
  output logic              dma_wp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

`ifdef ARB_WP_EN
  localparam bit WP_EN = 1'b1;
`else
  localparam bit WP_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] BURST_LAST = to_cnt(MAX_BURST - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = to_cnt(CPU_GAP);

  arb_state_e       state_q, state_d;
  logic             cpu_rdy_q, cpu_rdy_d;
  logic             dma_rvalid_q, dma_rvalid_d;
  logic             wp_err_q, wp_err_d;

  logic             mux_sel;
  logic             ack;
  logic             handback;
  logic             wp_hit;
  logic [CNT_W-1:0] burst_cnt;
  logic [CNT_W-1:0] gap_cnt;

  // A low dma_req in DMA_OWN does the handback work in that same cycle, so the
  // CPU regains RDY two cycles after the last ack whichever way the grant ends.
  always_comb begin
    state_d  = state_q;
    mux_sel  = MUX_CPU;
    ack      = 1'b0;
    handback = 1'b0;
    case (state_q)
      CPU_OWN: begin
        if (dma_req && gap_cnt == '0) state_d = HALT_WAIT;
      end
      HALT_WAIT: begin
        if (!cpu_wr) state_d = dma_req ? DMA_OWN : HANDBACK;
      end
      DMA_OWN: begin
        if (dma_req) begin
          mux_sel = MUX_DMA;
          ack     = 1'b1;
          if (burst_cnt == BURST_LAST) state_d = HANDBACK;
        end else begin
          handback = 1'b1;
          state_d  = CPU_OWN;
        end
      end
      HANDBACK: begin
        handback = 1'b1;
        state_d  = CPU_OWN;
      end
      default: state_d = CPU_OWN;
    endcase
  end

  assign wp_hit = WP_EN && ack && dma_we && (dma_addr >= WP_BASE);

  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    if (mux_sel == MUX_DMA) begin
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
      mem_re    = ack && !dma_we;
      mem_we    = ack && dma_we && !wp_hit;
    end else if (handback) begin
      mem_re = 1'b1;
    end else if (state_q == CPU_OWN) begin
      mem_re = cpu_rd;
      mem_we = cpu_wr;
    end else if (state_q == HALT_WAIT) begin
      mem_we = cpu_wr;
    end
  end

  always_comb begin
    cpu_rdy_d    = (state_d == CPU_OWN);
    dma_rvalid_d = ack && !dma_we;
    wp_err_d     = wp_err_q | wp_hit;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= CPU_OWN;
      cpu_rdy_q    <= 1'b1;
      dma_rvalid_q <= 1'b0;
      wp_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cpu_rdy_q    <= cpu_rdy_d;
      dma_rvalid_q <= dma_rvalid_d;
      wp_err_q     <= wp_err_d;
    end
  end

  arb_cycle_counter u_burst_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (handback),
    .load_val ('0),
    .inc      (ack),
    .dec      (1'b0),
    .count    (burst_cnt)
  );

  arb_cycle_counter u_gap_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (handback),
    .load_val (GAP_LOAD),
    .inc      (1'b0),
    .dec      (state_q == CPU_OWN),
    .count    (gap_cnt)
  );

  assign cpu_rdy    = cpu_rdy_q;
  assign cpu_rdata  = mem_rdata;
  assign dma_ack    = ack;
  assign dma_rdata  = mem_rdata;
  assign dma_rvalid = dma_rvalid_q;
  assign dma_wp_err = wp_err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: random data/addresses against a cycle-count reference.
module tb_mem_bus_arbiter;

  localparam int          MAX_BURST = 16;
  localparam int          CPU_GAP   = 4;
  localparam logic [15:0] WP_BASE   = 16'hFF00;
  localparam int          PERIOD    = MAX_BURST + CPU_GAP + 3;
`ifdef ARB_WP_EN
  localparam bit WP_ON = 1'b1;
`else
  localparam bit WP_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        cpu_rd = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [7:0]  cpu_rdata;
  logic        cpu_rdy;
  logic        dma_req = 1'b0;
  logic [15:0] dma_addr = '0;
  logic [7:0]  dma_wdata = '0;
  logic        dma_we = 1'b0;
  logic        dma_ack;
  logic [7:0]  dma_rdata;
  logic        dma_rvalid;
  logic        dma_wp_err;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_re;
  logic        mem_we;
  logic [7:0]  mem_rdata = '0;

  mem_bus_arbiter #(
    .MAX_BURST (MAX_BURST),
    .CPU_GAP   (CPU_GAP),
    .ADDR_W    (16),
    .DATA_W    (8),
    .WP_BASE   (WP_BASE)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rd     (cpu_rd),
    .cpu_wr     (cpu_wr),
    .cpu_rdata  (cpu_rdata),
    .cpu_rdy    (cpu_rdy),
    .dma_req    (dma_req),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_we     (dma_we),
    .dma_ack    (dma_ack),
    .dma_rdata  (dma_rdata),
    .dma_rvalid (dma_rvalid),
    .dma_wp_err (dma_wp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous memory array behind the arbiter; ref_mem is the expected contents.
  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];
  bit         exp_wp = 1'b0;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    cpu_rd = 1'b0; cpu_wr = 1'b0; dma_req = 1'b0;
    repeat (n) tick();
  endtask

  task automatic cpu_read(input logic [15:0] a);
    cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = a;
    @(negedge clk);
    chk("cpu_rd_rdy", cpu_rdy, 1);
    tick();
    cpu_rd = 1'b0;
    @(negedge clk);
    chk("cpu_rdata", cpu_rdata, ref_mem[a]);
    tick();
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    cpu_wr = 1'b1; cpu_rd = 1'b0; cpu_addr = a; cpu_wdata = d;
    @(negedge clk);
    chk("cpu_wr_rdy", cpu_rdy, 1);
    ref_mem[a] = d;
    tick();
    cpu_wr = 1'b0;
  endtask

  // One DMA burst of n transfers started from CPU_OWN with the gap expired. The CPU
  // reads cpu_a in cycle 0, issues n_wr writes to $0010.. while halted, then stalls on cpu_a.
  task automatic dma_burst(input int n, input bit we, input logic [15:0] base,
                           input int n_wr, input logic [15:0] cpu_a,
                           input bit use_d0, input logic [7:0] d0);
    logic [7:0] wdat [0:15];
    int first, acks, last;
    bit exp_rv;
    for (int i = 0; i < 16; i++) wdat[i] = 8'($urandom);
    if (use_d0) wdat[0] = d0;
    first = 2 + n_wr;
    last  = first + n + 1;
    acks  = 0;
    for (int c = 0; c <= last; c++) begin
      dma_req   = (acks < n);
      dma_addr  = base + 16'(acks);
      dma_wdata = wdat[acks % 16];
      dma_we    = we;
      if (c >= 1 && c <= n_wr) begin
        cpu_rd = 1'b0; cpu_wr = 1'b1;
        cpu_addr = 16'h0010 + 16'(c - 1); cpu_wdata = 8'($urandom);
        ref_mem[cpu_addr] = cpu_wdata;
      end else begin
        cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = cpu_a;
      end
      @(negedge clk);
      exp_rv = !we && c > first && c <= first + n;
      chk("burst_ack", dma_ack, (c >= first && c < first + n));
      chk("burst_rvalid", dma_rvalid, exp_rv);
      if (exp_rv) chk("burst_rdata", dma_rdata, ref_mem[base + 16'(c - first - 1)]);
      chk("burst_rdy", cpu_rdy, (c == 0 || c == last));
      if (c == 1)    chk("cpu_rdata_pre", cpu_rdata, ref_mem[cpu_a]);
      if (c == last) chk("cpu_rdata_replay", cpu_rdata, ref_mem[cpu_a]);
      if (dma_ack) begin
        if (we) begin
          if (WP_ON && dma_addr >= WP_BASE) exp_wp = 1'b1;
          else ref_mem[dma_addr] = dma_wdata;
        end
        acks++;
      end
      tick();
    end
    cpu_rd = 1'b0; cpu_wr = 1'b0; dma_req = 1'b0;
  endtask

  function automatic bit cont_ack(input int c);
    if (c < 2) return 1'b0;
    return ((c - 2) % PERIOD) < MAX_BURST;
  endfunction

  function automatic bit cont_rdy(input int c);
    int r;
    if (c == 0) return 1'b1;
    if (c < 2) return 1'b0;
    r = (c - 2) % PERIOD;
    return (r > MAX_BURST) && (r <= MAX_BURST + CPU_GAP + 1);
  endfunction

  // dma_req held high throughout: bursts of MAX_BURST separated by handback + CPU gap.
  task automatic dma_continuous(input int cycles);
    logic [15:0] base, prev_addr;
    int acks;
    bit prev_exp;
    base = 16'h2000 + 16'($urandom_range(0, 255));
    acks = 0; prev_exp = 1'b0; prev_addr = base;
    cpu_rd = 1'b0; cpu_wr = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = base + 16'(acks);
      @(negedge clk);
      chk("cont_ack", dma_ack, cont_ack(c));
      chk("cont_rvalid", dma_rvalid, prev_exp);
      if (prev_exp) chk("cont_rdata", dma_rdata, ref_mem[prev_addr]);
      chk("cont_rdy", cpu_rdy, cont_rdy(c));
      prev_exp  = cont_ack(c);
      prev_addr = dma_addr;
      if (dma_ack) acks++;
      tick();
    end
    dma_req = 1'b0;
  endtask

  initial begin
    logic [15:0] a;
    logic [7:0]  d;
    int          n;
    logic [15:0] base;

    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end

    repeat (3) tick();
    @(negedge clk);
    chk("rst_rdy", cpu_rdy, 1);
    chk("rst_ack", dma_ack, 0);
    chk("rst_rvalid", dma_rvalid, 0);
    chk("rst_wp_err", dma_wp_err, 0);
    chk("rst_mem_re", mem_re, 0);
    chk("rst_mem_we", mem_we, 0);
    tick();
    reset_n = 1'b1;
    tick();

    cpu_read(16'hFF00);
    for (int i = 0; i < 4; i++) begin
      a = 16'h5000 + 16'($urandom_range(0, 4095));
      d = 8'($urandom);
      cpu_write(a, d);
      cpu_read(a);
    end

    idle(8);
    dma_burst(3, 1'b0, 16'h0200, 0, 16'h4000 + 16'($urandom_range(0, 255)), 1'b0, 8'h00);

    idle(8);
    dma_burst(2, 1'b0, 16'h0300, 1, 16'h4100 + 16'($urandom_range(0, 255)), 1'b0, 8'h00);
    cpu_read(16'h0010);

    for (int k = 0; k < 3; k++) begin
      n = $urandom_range(1, 8);
      base = 16'h1000 + 16'($urandom_range(0, 16'h0EFF));
      idle(8);
      dma_burst(n, 1'b1, base, $urandom_range(0, 2), 16'h4200 + 16'($urandom_range(0, 255)), 1'b0, 8'h00);
      idle(8);
      dma_burst(n, 1'b0, base, 0, 16'h4300 + 16'($urandom_range(0, 255)), 1'b0, 8'h00);
    end

    idle(8);
    dma_burst(1, 1'b1, 16'hFF10, 0, 16'h4400, 1'b1, 8'hAA);
    @(negedge clk);
    chk("wp_err", dma_wp_err, exp_wp);
    tick();
    cpu_read(16'hFF10);
    cpu_write(16'hFF20, 8'h5C);
    cpu_read(16'hFF20);

    idle(8);
    dma_continuous(2 + 2 * PERIOD + 2);

    // Reset during DMA_OWN after five acks; the sixth read's rvalid must be dropped.
    idle(8);
    base = 16'h3000 + 16'($urandom_range(0, 255));
    n = 0;
    for (int c = 0; c < 10 + MAX_BURST + 2; c++) begin
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = base + 16'(n);
      reset_n = (c != 7);
      @(negedge clk);
      if (c < 7) chk("prerst_ack", dma_ack, (c >= 2));
      if (c == 8) begin
        chk("postrst_rdy", cpu_rdy, 1);
        chk("postrst_rvalid", dma_rvalid, 0);
        chk("postrst_wp_err", dma_wp_err, 0);
        exp_wp = 1'b0;
      end
      if (c >= 8) chk("postrst_ack", dma_ack, (c >= 10 && c < 10 + MAX_BURST));
      if (c == 9) chk("postrst_halt_rdy", cpu_rdy, 0);
      if (dma_ack) n++;
      tick();
    end
    reset_n = 1'b1;
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
